// File: rtl/fix_parser_tag_extract.sv
// fix_parser_tag_extract
// Parses a raw FIX byte stream ("tag=value<SOH>...") and converts each decimal
// tag number to binary. It then pushes the tag into the downstream tag FIFO
// through that FIFO's write handshake. Malformed fields raise a one-cycle
// parse_err_o pulse.
// Optional feature: define FIX_PARSER_CKSUM_EN to verify the FIX checksum field
// (tag 10) against the running mod-256 byte sum. When it is undefined, the
// checksum logic is absent and cksum_ok_o/cksum_err_o are tied low.
module fix_parser_tag_extract #(
  parameter int         DATA_WIDTH = 32,
  parameter int         MAX_DIGITS = 9,
  parameter logic [7:0] SOH_CHAR   = 8'h01,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  fifo_full_i,
  output logic                  tag_wr_cs_o,
  output logic                  tag_wr_en_o,
  output logic [DATA_WIDTH-1:0] tag_data_o,
  output logic                  parse_err_o,
  output logic [CNT_WIDTH-1:0]  tag_cnt_o,
  output logic                  cksum_ok_o,
  output logic                  cksum_err_o
);

  localparam int         DCNT_W  = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] EQ_CHAR = 8'h3D;

  typedef enum logic [1:0] {S_TAG, S_PUSH, S_VALUE, S_ERR} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DCNT_W-1:0]     dcnt;
  logic                  accept;
  logic                  is_digit;
  logic                  wr;

  // One decimal digit step: a*10 + digit, where the digit is the low nibble of an ASCII '0'-'9'.
  function automatic logic [DATA_WIDTH-1:0] dec_step(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [7:0]            b);
    return a * DATA_WIDTH'(10) + DATA_WIDTH'(b[3:0]);
  endfunction

  // No byte is taken while a tag waits for FIFO space, and none is taken during reset.
  assign byte_ready_o = !rst && (state != S_PUSH);
  assign accept       = byte_valid_i && byte_ready_o;
  assign is_digit     = (byte_i >= 8'h30) && (byte_i <= 8'h39);

  // The write is decoded from the live full flag, so a write can never overlap full.
  assign wr          = !rst && (state == S_PUSH) && !fifo_full_i;
  assign tag_wr_cs_o = wr;
  assign tag_wr_en_o = wr;

  // Field parser FSM: decodes the tag, hands it to the FIFO, then skips the value or the bad field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_TAG;
      acc         <= '0;
      dcnt        <= '0;
      tag_data_o  <= '0;
      tag_cnt_o   <= '0;
      parse_err_o <= 1'b0;
    end else begin
      parse_err_o <= 1'b0;
      case (state)
        S_TAG: begin
          if (accept) begin
            if (is_digit) begin
              if (dcnt == DCNT_W'(MAX_DIGITS)) begin
                state       <= S_ERR;
                parse_err_o <= 1'b1;
              end else begin
                acc  <= dec_step(acc, byte_i);
                dcnt <= dcnt + 1'b1;
              end
            end else if (byte_i == EQ_CHAR) begin
              if (dcnt != '0) begin
                tag_data_o <= acc;
                state      <= S_PUSH;
              end else begin
                state       <= S_ERR;
                parse_err_o <= 1'b1;
              end
            end else if (byte_i == SOH_CHAR && dcnt == '0) begin
              state <= S_TAG;
            end else begin
              state       <= S_ERR;
              parse_err_o <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          if (!fifo_full_i) begin
            tag_cnt_o <= tag_cnt_o + 1'b1;
            state     <= S_VALUE;
          end
        end
        S_VALUE, S_ERR: begin
          if (accept && byte_i == SOH_CHAR) begin
            state <= S_TAG;
            acc   <= '0;
            dcnt  <= '0;
          end
        end
        default: state <= S_TAG;
      endcase
    end
  end

`ifdef FIX_PARSER_CKSUM_EN
  logic [7:0] sum;
  logic [7:0] snap;
  logic       is_ck;
  logic [9:0] cval;
  logic [2:0] ccnt;
  logic       cbad;

  // Running byte sum, snapshot at each value SOH, and decoding and comparison of the tag-10 value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum         <= '0;
      snap        <= '0;
      is_ck       <= 1'b0;
      cval        <= '0;
      ccnt        <= '0;
      cbad        <= 1'b0;
      cksum_ok_o  <= 1'b0;
      cksum_err_o <= 1'b0;
    end else begin
      cksum_ok_o  <= 1'b0;
      cksum_err_o <= 1'b0;
      if (accept) begin
        sum <= sum + byte_i;
      end
      if (state == S_TAG && accept && byte_i == EQ_CHAR && dcnt != '0) begin
        is_ck <= (acc == DATA_WIDTH'(10));
        cval  <= '0;
        ccnt  <= '0;
        cbad  <= 1'b0;
      end
      if (state == S_VALUE && accept) begin
        if (byte_i == SOH_CHAR) begin
          if (is_ck) begin
            if (!cbad && ccnt == 3'd3 && cval == {2'b00, snap}) begin
              cksum_ok_o <= 1'b1;
            end else begin
              cksum_err_o <= 1'b1;
            end
            // The checksum field closes the message; start the next sum from zero.
            sum   <= '0;
            is_ck <= 1'b0;
          end else begin
            snap <= sum + byte_i;
          end
        end else if (is_digit && ccnt < 3'd3) begin
          cval <= cval * 10'd10 + {6'd0, byte_i[3:0]};
          ccnt <= ccnt + 1'b1;
        end else begin
          cbad <= 1'b1;
        end
      end
    end
  end
`else
  assign cksum_ok_o  = 1'b0;
  assign cksum_err_o = 1'b0;
`endif

endmodule
